// File: rtl/adder_pkg.sv
// Shared types for the chunked add/subtract unit: FSM state encoding used by
// the datapath controller and by anything that observes its state.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_chunk.sv
// Combinational N-bit ripple adder slice; also exposes the carry into its
// top bit so the caller can form a signed-overflow flag.
module adder_chunk #(
  parameter int N = 4
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic c;

  always_comb begin
    c    = cin;
    cmsb = cin;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) cmsb = c;
      sum[i] = A[i] ^ B[i] ^ c;
      c      = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_adder_nb.sv
// Multi-cycle add/subtract unit: resolves CHUNK bits per cycle, LSB chunk
// first, with the carry registered between chunks and valid/ready on both sides.
module seq_adder_nb
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("seq_adder_nb: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bx_q;
  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;
  logic             ch_cmsb;

  always_comb begin
    a_slice = a_q[CHUNK-1:0];
    b_slice = bx_q[CHUNK-1:0];
    for (int i = 1; i < NCHUNK; i++) begin
      if (k == KW'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = bx_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.N(CHUNK)) u_chunk (
    .A    (a_slice),
    .B    (b_slice),
    .cin  (carry),
    .sum  (ch_sum),
    .cout (ch_cout),
    .cmsb (ch_cmsb)
  );

  // Subtract is folded in at capture: B is inverted once and the borrow-in
  // becomes an inverted carry-in, so the chunk datapath only ever adds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      bx_q      <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            bx_q     <= sub ? ~B : B;
            carry    <= cin ^ sub;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (k == KW'(i)) sum[i*CHUNK +: CHUNK] <= ch_sum;
          end
          carry <= ch_cout;
          if (k == KLAST) begin
            cout      <= ch_cout;
            ovf       <= ch_cout ^ ch_cmsb;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_nb.sv
// Bench for seq_adder_nb in three geometries (16/4, 4/4, 32/8): vector table,
// handshake/reset corner sequences and a scoreboarded random run.
module tb_seq_adder_nb;
  import adder_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_valid, in_ready, out_valid, out_ready, cout, ovf;
  logic        sub, cin;
  logic [31:0] a, b;
  logic [15:0] s16;
  logic [3:0]  s4;
  logic [31:0] s32;
  logic [31:0] sum_w [3];

  always #5 clk = ~clk;

  seq_adder_nb #(.WIDTH(16), .CHUNK(4)) u16 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(a[15:0]), .B(b[15:0]), .sub(sub), .cin(cin), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(s16), .cout(cout[0]), .ovf(ovf[0]));

  seq_adder_nb #(.WIDTH(4), .CHUNK(4)) u4 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(a[3:0]), .B(b[3:0]), .sub(sub), .cin(cin), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(s4), .cout(cout[1]), .ovf(ovf[1]));

  seq_adder_nb #(.WIDTH(32), .CHUNK(8)) u32 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .A(a), .B(b), .sub(sub), .cin(cin), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .sum(s32), .cout(cout[2]), .ovf(ovf[2]));

  assign sum_w[0] = {16'b0, s16};
  assign sum_w[1] = {28'b0, s4};
  assign sum_w[2] = s32;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    int          cfg;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  int   wid [3] = '{16, 4, 32};
  int   nch [3] = '{4, 1, 4};
  exp_t sbq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: whole-word add in 64 bits, carry into MSB from the low WIDTH-1 bits.
  function automatic exp_t model(input int w, input logic [31:0] a_, input logic [31:0] b_,
                                 input logic s, input logic c);
    logic [63:0] m, bx, t, lo, ci;
    exp_t r;
    m  = (64'd1 << w) - 64'd1;
    ci = {63'b0, c ^ s};
    bx = s ? (~{32'b0, b_}) & m : {32'b0, b_} & m;
    t  = ({32'b0, a_} & m) + bx + ci;
    lo = ({32'b0, a_} & (m >> 1)) + (bx & (m >> 1)) + ci;
    r.sum  = t[31:0] & m[31:0];
    r.cout = t[w];
    r.ovf  = lo[w-1] ^ t[w];
    return r;
  endfunction

  task automatic do_op(input int cfg, input logic [31:0] a_, input logic [31:0] b_,
                       input logic s, input logic c, input exp_t e, input string nm);
    int   lat;
    exp_t x;
    @(negedge clk);
    chk({nm, " ready_before"}, {31'b0, in_ready[cfg]}, 32'd1);
    a = a_; b = b_; sub = s; cin = c;
    in_valid[cfg] = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid[cfg] = 1'b0;
    lat = 0;
    while (!out_valid[cfg] && lat < 20) begin
      chk({nm, " ready_busy"}, {31'b0, in_ready[cfg]}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, " latency"}, lat, nch[cfg]);
    if (sbq.size() == 0) begin
      chk({nm, " scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      x = sbq.pop_front();
      chk({nm, " sum"}, sum_w[cfg], x.sum);
      chk({nm, " cout"}, {31'b0, cout[cfg]}, {31'b0, x.cout});
      chk({nm, " ovf"}, {31'b0, ovf[cfg]}, {31'b0, x.ovf});
    end
    @(negedge clk);
    out_ready[cfg] = 1'b1;
    @(posedge clk); #1;
    out_ready[cfg] = 1'b0;
    chk({nm, " valid_drop"}, {31'b0, out_valid[cfg]}, 32'd0);
    chk({nm, " ready_after"}, {31'b0, in_ready[cfg]}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [18];
    exp_t e;
    int   cfg;
    logic [31:0] ra, rb;
    logic rs, rc;

    tbl = '{
      '{0, 32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0},
      '{0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1},
      '{0, 32'hFFFF, 32'h0001, 1'b0, 1'b1, 32'h0001, 1'b1, 1'b0},
      '{0, 32'h0005, 32'h0007, 1'b1, 1'b0, 32'hFFFE, 1'b0, 1'b0},
      '{0, 32'h8000, 32'h0001, 1'b1, 1'b0, 32'h7FFF, 1'b1, 1'b1},
      '{0, 32'h0010, 32'h0001, 1'b1, 1'b1, 32'h000E, 1'b1, 1'b0},
      '{1, 32'h3, 32'h1, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0},
      '{1, 32'h7, 32'h1, 1'b0, 1'b0, 32'h8, 1'b0, 1'b1},
      '{1, 32'hF, 32'h1, 1'b0, 1'b1, 32'h1, 1'b1, 1'b0},
      '{1, 32'h5, 32'h7, 1'b1, 1'b0, 32'hE, 1'b0, 1'b0},
      '{1, 32'h8, 32'h1, 1'b1, 1'b0, 32'h7, 1'b1, 1'b1},
      '{1, 32'hA, 32'h1, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0},
      '{2, 32'h000000FF, 32'h1, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0},
      '{2, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
      '{2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0},
      '{2, 32'h00000005, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0},
      '{2, 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1},
      '{2, 32'h00000010, 32'h1, 1'b1, 1'b1, 32'h0000000E, 1'b1, 1'b0}
    };

    reset = 1'b1;
    in_valid = '0; out_ready = '0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d sum", i), sum_w[i], 32'd0);
      chk($sformatf("rst%0d cout_ovf", i), {30'b0, cout[i], ovf[i]}, 32'd0);
      chk($sformatf("rst%0d out_valid", i), {31'b0, out_valid[i]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst%0d in_ready", i), {31'b0, in_ready[i]}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      e.sum = tbl[i].es; e.cout = tbl[i].ec; e.ovf = tbl[i].eo;
      do_op(tbl[i].cfg, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, e, $sformatf("tbl%0d", i));
    end

    // Result held in DONE while the consumer stalls and new operands are offered.
    @(negedge clk);
    a = 32'h1111; b = 32'h2222; sub = 1'b0; cin = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold first_valid", {31'b0, out_valid[0]}, 32'd1);
    chk("hold first_sum", sum_w[0], 32'h3333);
    @(negedge clk);
    a = 32'hAAAA; b = 32'h5555; sub = 1'b1; cin = 1'b1;
    in_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d valid", i), {31'b0, out_valid[0]}, 32'd1);
      chk($sformatf("hold%0d sum", i), sum_w[0], 32'h3333);
      chk($sformatf("hold%0d flags", i), {30'b0, cout[0], ovf[0]}, 32'd0);
      chk($sformatf("hold%0d in_ready", i), {31'b0, in_ready[0]}, 32'd0);
      chk($sformatf("hold%0d state", i), 32'(u16.state), 32'(DONE));
      chk($sformatf("hold%0d a_latched", i), {16'b0, u16.a_q}, 32'h1111);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("hold release_state", 32'(u16.state), 32'(IDLE));
    chk("hold release_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("hold release_ready", {31'b0, in_ready[0]}, 32'd1);

    // Asynchronous reset after two chunks of RUN.
    @(negedge clk);
    a = 32'h1234; b = 32'h4321; sub = 1'b0; cin = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("arst mid_state", 32'(u16.state), 32'(RUN));
    chk("arst partial_sum", {24'b0, sum_w[0][7:0]}, 32'h55);
    #2;
    reset = 1'b1;
    #1;
    chk("arst sum", sum_w[0], 32'd0);
    chk("arst flags", {30'b0, cout[0], ovf[0]}, 32'd0);
    chk("arst out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("arst state", 32'(u16.state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst in_ready", {31'b0, in_ready[0]}, 32'd1);
    e.sum = 32'h5555; e.cout = 1'b0; e.ovf = 1'b0;
    do_op(0, 32'h1234, 32'h4321, 1'b0, 1'b0, e, "arst_follow");

    for (int i = 0; i < 1000; i++) begin
      cfg = i % 3;
      ra = $urandom; rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      e = model(wid[cfg], ra, rb, rs, rc);
      do_op(cfg, ra, rb, rs, rc, e, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
